posit_encode_round: RTL and testbench

- Pipelined posit encoder and rounder, the back end of the posit arithmetic datapath.
- Accepts decoded posit fields as produced by the adder (sign, scale factor, fraction, guard, sticky, nzn). Emits the rounded N-bit posit word.
- Uses round-to-nearest-even, posit saturation (never rounds to zero or NaR) and a valid/ready handshake.
- Two register stages: stage 1 builds and shifts the regime; stage 2 rounds and clamps.

---
 rtl/posit_pkg.sv | 24 ++
 rtl/posit_regime_shifter.sv | 61 ++++++
 rtl/posit_encode_round.sv | 90 +++++++++
 tb/tb_posit_encode_round.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/posit_pkg.sv
// Shared widths, constants and stage types for the 16-bit, es=1 posit encode/round back end.
package posit_pkg;

    localparam int N      = 16;
    localparam int ES     = 1;
    localparam int SF_W   = N - 9;
    localparam int MANT_W = N - 4;
    localparam int BODY_W = N - 1;

    localparam logic [N-1:0] ZERO   = 16'h0000;
    localparam logic [N-1:0] NAR    = 16'h8000;
    localparam logic [N-1:0] MAXPOS = 16'h7FFF;
    localparam logic [N-1:0] MINPOS = 16'h0001;

    // Everything stage 2 needs to finish the word.
    typedef struct packed {
        logic              s;
        logic              special;
        logic [BODY_W-1:0] body;
        logic              rb;
        logic              st;
    } stage1_t;

endpackage

// File: rtl/posit_regime_shifter.sv
// Combinational stage-1 datapath: builds the regime from the scale factor, appends the
// exponent/fraction tail and splits the result into body, round bit and sticky.
module posit_regime_shifter
    import posit_pkg::*;
(
    input  logic              s,
    input  logic [SF_W-1:0]   sf,
    input  logic [MANT_W-1:0] mant,
    input  logic              guard,
    input  logic              sticky,
    output logic [BODY_W-1:0] body,
    output logic              rb,
    output logic              st
);

    localparam int TAIL_W = MANT_W + 3;
    localparam int WORD_W = BODY_W + TAIL_W;
    localparam logic [BODY_W-1:0] ALL_ONES = '1;

    logic [SF_W-2:0]   k_u;
    logic [SF_W-2:0]   k_neg;
    logic              e;
    logic [4:0]        reg_len;
    logic [4:0]        shamt;
    logic [BODY_W-1:0] reg_bits;
    logic [WORD_W-1:0] word;

    // sf >>> 1 is just sf without its LSB, read as a signed 6-bit k.
    assign k_u   = sf[SF_W-1:1];
    assign k_neg = '0 - k_u;
    assign e     = sf[0];

    // Regime right-aligned in reg_bits, reg_len of its bits meaningful.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        reg_len  = 5'(BODY_W);
        reg_bits = '0;
        if (!k_u[SF_W-2]) begin
            if (k_u > 6'd13) begin
                reg_bits = ALL_ONES;
            end else begin
                reg_len  = 5'(k_u) + 5'd2;
                reg_bits = ~(ALL_ONES << (k_u + 6'd1)) << 1;
            end
        end else begin
            if (k_neg <= 6'd14) begin
                reg_len  = 5'(k_neg) + 5'd1;
                reg_bits = BODY_W'(1);
            end
        end
    end

    // Left-justify the regime; the unused high bits of reg_bits fall off the top.
    assign shamt = 5'(BODY_W) - reg_len;
    assign word  = {reg_bits ^ {BODY_W{s}}, e ^ s, mant, guard, sticky} << shamt;

    assign body = word[WORD_W-1 -: BODY_W];
    assign rb   = word[TAIL_W-1];
    assign st   = |word[TAIL_W-2:0];

endmodule

// File: rtl/posit_encode_round.sv
// Two-stage posit encoder/rounder with valid/ready flow control: stage 1 places the regime,
// stage 2 applies round-to-nearest-even and saturates away from zero and NaR.
module posit_encode_round
    import posit_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic              i_s,
    input  logic [SF_W-1:0]   i_sf,
    input  logic [MANT_W-1:0] i_mant,
    input  logic              i_guard,
    input  logic              i_sticky,
    input  logic              i_nzn,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [N-1:0]      o_posit
);

    logic              stall;
    logic              v1_q;
    logic              v2_q;
    stage1_t           s1_d;
    stage1_t           s1_q;
    logic [N-1:0]      posit_d;
    logic [N-1:0]      posit_q;
    logic [BODY_W-1:0] sh_body;
    logic              sh_rb;
    logic              sh_st;
    logic              round_up;
    logic [BODY_W:0]   sum;

    // A single global enable: the whole pipe freezes, bubbles included.
    assign stall   = v2_q & ~i_ready;
    assign o_ready = ~stall;
    assign o_valid = v2_q;
    assign o_posit = posit_q;

    posit_regime_shifter u_shifter (
        .s      (i_s),
        .sf     (i_sf),
        .mant   (i_mant),
        .guard  (i_guard),
        .sticky (i_sticky),
        .body   (sh_body),
        .rb     (sh_rb),
        .st     (sh_st)
    );

    always_comb begin
        s1_d = '{s: i_s, special: ~i_nzn, body: sh_body, rb: sh_rb, st: sh_st};
        if (!i_nzn) begin
            s1_d.body = '0;
            s1_d.rb   = 1'b0;
            s1_d.st   = 1'b0;
        end
    end

    // Carry out of the body means we were already at the largest magnitude.
    assign round_up = s1_q.rb & (s1_q.body[0] | s1_q.st);
    assign sum      = {1'b0, s1_q.body} + {{BODY_W{1'b0}}, round_up};

    always_comb begin
        posit_d = {s1_q.s, sum[BODY_W-1:0]};
        if (s1_q.special) begin
            posit_d = s1_q.s ? NAR : ZERO;
        end else if (sum[BODY_W]) begin
            posit_d = {s1_q.s, MAXPOS[BODY_W-1:0]};
        end else if (sum[BODY_W-1:0] == '0) begin
            posit_d = {s1_q.s, MINPOS[BODY_W-1:0]};
        end
    end

    // NOTE: state uses non-blocking assignments so both stages sample pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            s1_q    <= '0;
            posit_q <= '0;
        end else if (!stall) begin
            v1_q    <= i_valid;
            v2_q    <= v1_q;
            s1_q    <= s1_d;
            posit_q <= posit_d;
        end
    end

endmodule

// File: tb/tb_posit_encode_round.sv
// Self-checking bench for posit_encode_round: directed corner cases, randomized traffic with
// backpressure against a bit-list reference model, stall behaviour and mid-flight reset.
module tb_posit_encode_round;

    typedef struct {
        logic        s;
        logic [6:0]  sf;
        logic [11:0] mant;
        logic        g;
        logic        st;
        logic        nzn;
        logic [15:0] exp;
    } item_t;

    logic        clk;
    logic        rst_n;
    logic        i_valid;
    logic        o_ready;
    logic        i_s;
    logic [6:0]  i_sf;
    logic [11:0] i_mant;
    logic        i_guard;
    logic        i_sticky;
    logic        i_nzn;
    logic        o_valid;
    logic        i_ready;
    logic [15:0] o_posit;

    int n_vec = 0;
    int n_err = 0;
    item_t items[$];
    logic [15:0] obs[$];

    posit_encode_round dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_valid  (i_valid),
        .o_ready  (o_ready),
        .i_s      (i_s),
        .i_sf     (i_sf),
        .i_mant   (i_mant),
        .i_guard  (i_guard),
        .i_sticky (i_sticky),
        .i_nzn    (i_nzn),
        .o_valid  (o_valid),
        .i_ready  (i_ready),
        .o_posit  (o_posit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: regime as a list of bits, then tail bits, then plain integer rounding.
    function automatic logic [15:0] model(input item_t it);
        int sfi, k, e, body, rb, stk;
        bit q[$];
        if (!it.nzn) return it.s ? 16'h8000 : 16'h0000;
        sfi = int'($signed(it.sf));
        k   = sfi >>> 1;
        e   = sfi - 2 * k;
        if (k >= 0) begin
            for (int i = 0; i <= k; i++) q.push_back(1'b1);
            q.push_back(1'b0);
        end else begin
            for (int i = 0; i < -k; i++) q.push_back(1'b0);
            q.push_back(1'b1);
        end
        while (q.size() > 15) void'(q.pop_back());
        foreach (q[i]) q[i] = q[i] ^ it.s;
        q.push_back(bit'(e) ^ it.s);
        for (int i = 11; i >= 0; i--) q.push_back(it.mant[i]);
        q.push_back(it.g);
        q.push_back(it.st);
        body = 0;
        for (int i = 0; i < 15; i++) body = body * 2 + int'(q[i]);
        rb  = int'(q[15]);
        stk = 0;
        for (int i = 16; i < q.size(); i++) stk = stk | int'(q[i]);
        if (rb != 0 && ((body % 2) == 1 || stk != 0)) body = body + 1;
        if (body > 32767) body = 32767;
        if (body == 0) body = 1;
        return {it.s, 15'(body)};
    endfunction

    function automatic item_t mk(input logic s, input int sf, input logic [11:0] mant,
                                 input logic g, input logic st, input logic nzn,
                                 input logic [15:0] exp);
        item_t it;
        it.s = s; it.sf = 7'(sf); it.mant = mant; it.g = g; it.st = st; it.nzn = nzn;
        it.exp = exp;
        return it;
    endfunction

    function automatic item_t rnd_item();
        item_t it;
        it.s    = 1'($urandom_range(0, 1));
        it.sf   = 7'($urandom_range(0, 127));
        it.mant = 12'($urandom_range(0, 4095));
        it.g    = 1'($urandom_range(0, 1));
        it.st   = 1'($urandom_range(0, 1));
        it.nzn  = ($urandom_range(0, 15) != 0);
        it.exp  = model(it);
        return it;
    endfunction

    task automatic drive(input item_t it);
        i_s = it.s; i_sf = it.sf; i_mant = it.mant;
        i_guard = it.g; i_sticky = it.st; i_nzn = it.nzn;
    endtask

    // Pushes items[] through the DUT and collects accepted outputs into obs[].
    // mode 0: always ready; mode 1: random valid gaps and random backpressure.
    task automatic run_stream(input int mode, output bit timed_out);
        int sent = 0;
        int cyc  = 0;
        obs.delete();
        while (obs.size() < items.size() && cyc < 4000) begin
            @(negedge clk);
            i_ready = (mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (sent < items.size() && (mode == 0 || $urandom_range(0, 4) != 0)) begin
                drive(items[sent]);
                i_valid = 1'b1;
            end else begin
                i_valid = 1'b0;
            end
            #1;
            if (o_valid && i_ready) obs.push_back(o_posit);
            if (i_valid && o_ready) sent++;
            cyc++;
        end
        timed_out = (obs.size() < items.size());
        @(negedge clk);
        i_valid = 1'b0;
        i_ready = 1'b1;
    endtask

    task automatic compare_run(input string name, input int mode);
        bit to;
        run_stream(mode, to);
        n_vec++;
        if (to) $display("FAIL %s timeout: got %0d outputs, required %0d", name, obs.size(), items.size());
        if (to) n_err++;
        foreach (obs[i]) begin
            n_vec++;
            if (obs[i] !== items[i].exp) begin
                n_err++;
                $display("FAIL %s item %0d: got %h, required %h", name, i, obs[i], items[i].exp);
            end
        end
        items.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; i_valid = 1'b0; i_ready = 1'b1;
        drive(mk(0, 0, 12'h000, 0, 0, 1, 16'h0));
        #2;
        n_vec++;
        if (o_valid !== 1'b0 || o_posit !== 16'h0000 || o_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset: got valid=%b posit=%h ready=%b, required 0/0000/1", o_valid, o_posit, o_ready);
        end
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_encode();
        items.push_back(mk(0,   0, 12'h000, 0, 0, 1, 16'h4000));
        items.push_back(mk(0,   1, 12'h800, 0, 0, 1, 16'h5800));
        items.push_back(mk(1,  -1, 12'h000, 0, 0, 1, 16'hC000));
        items.push_back(mk(0,   5, 12'h123, 0, 0, 0, 16'h0000));
        items.push_back(mk(1, -17, 12'hABC, 1, 1, 0, 16'h8000));
        compare_run("encode", 0);
    endtask

    task automatic test_rounding();
        items.push_back(mk(0, 0, 12'h000, 1, 0, 1, 16'h4000));
        items.push_back(mk(0, 0, 12'h000, 1, 1, 1, 16'h4001));
        items.push_back(mk(0, 0, 12'h001, 1, 0, 1, 16'h4002));
        items.push_back(mk(0, 0, 12'h001, 0, 1, 1, 16'h4001));
        compare_run("rounding", 0);
    endtask

    task automatic test_saturation();
        items.push_back(mk(0,  40, 12'h000, 0, 0, 1, 16'h7FFF));
        items.push_back(mk(0, -40, 12'h000, 0, 0, 1, 16'h0001));
        items.push_back(mk(1,  40, 12'h000, 0, 0, 1, 16'h8001));
        items.push_back(mk(1, -40, 12'h000, 0, 0, 1, 16'hFFFF));
        items.push_back(mk(0,  26, 12'h000, 0, 0, 1, 16'h7FFE));
        items.push_back(mk(0,  29, 12'h000, 0, 0, 1, 16'h7FFF));
        items.push_back(mk(0, -28, 12'h000, 0, 0, 1, 16'h0001));
        items.push_back(mk(0, -29, 12'hFFF, 1, 1, 1, 16'h0001));
        compare_run("saturation", 0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) items.push_back(rnd_item());
        compare_run("random", 1);
    endtask

    // 8 items back to back, downstream stalls for 3 cycles mid-stream.
    task automatic test_back_to_back();
        item_t exp_q[$];
        item_t src[$];
        int sent = 0;
        int got  = 0;
        int cyc  = 0;
        for (int i = 0; i < 8; i++) src.push_back(rnd_item());
        while (got < 8 && cyc < 100) begin
            @(negedge clk);
            i_ready = !(cyc >= 4 && cyc < 7);
            i_valid = (sent < 8);
            if (sent < 8) drive(src[sent]);
            #1;
            if (!i_ready && o_valid) begin
                n_vec++;
                if (o_ready !== 1'b0) begin
                    n_err++;
                    $display("FAIL b2b stall ready cycle %0d: got %b, required 0", cyc, o_ready);
                end
            end
            if (o_valid && i_ready) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL b2b extra output: got %h, required none", o_posit);
                end else begin
                    if (o_posit !== exp_q[0].exp) begin
                        n_err++;
                        $display("FAIL b2b item %0d: got %h, required %h", got, o_posit, exp_q[0].exp);
                    end
                    void'(exp_q.pop_front());
                end
                got++;
            end
            if (i_valid && o_ready) begin
                exp_q.push_back(src[sent]);
                sent++;
            end
            cyc++;
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        n_vec++;
        if (got != 8) begin
            n_err++;
            $display("FAIL b2b count: got %0d outputs, required 8", got);
        end
        @(negedge clk); #1;
        n_vec++;
        if (o_valid !== 1'b0) begin
            n_err++;
            $display("FAIL b2b drain: got valid=%b, required 0", o_valid);
        end
    endtask

    task automatic test_reset_midflight();
        item_t a, b, c;
        a = rnd_item(); b = rnd_item(); c = rnd_item();
        i_ready = 1'b1;
        @(negedge clk); drive(a); i_valid = 1'b1;
        @(negedge clk); drive(b);
        @(negedge clk); i_valid = 1'b0;
        #1;
        n_vec++;
        if (o_valid !== 1'b1 || o_posit !== a.exp) begin
            n_err++;
            $display("FAIL midreset pre: got valid=%b posit=%h, required 1/%h", o_valid, o_posit, a.exp);
        end
        #1 rst_n = 1'b0;
        #1;
        n_vec++;
        if (o_valid !== 1'b0 || o_posit !== 16'h0000) begin
            n_err++;
            $display("FAIL midreset flush: got valid=%b posit=%h, required 0/0000", o_valid, o_posit);
        end
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk); drive(c); i_valid = 1'b1;
        @(negedge clk); i_valid = 1'b0;
        #1;
        n_vec++;
        if (o_valid !== 1'b0) begin
            n_err++;
            $display("FAIL midreset early: got valid=%b, required 0", o_valid);
        end
        @(negedge clk); #1;
        n_vec++;
        if (o_valid !== 1'b1 || o_posit !== c.exp) begin
            n_err++;
            $display("FAIL midreset latency: got valid=%b posit=%h, required 1/%h", o_valid, o_posit, c.exp);
        end
        @(negedge clk); #1;
        n_vec++;
        if (o_valid !== 1'b0) begin
            n_err++;
            $display("FAIL midreset stale: got valid=%b, required 0", o_valid);
        end
    endtask

    initial begin
        test_reset();
        test_encode();
        test_rounding();
        test_saturation();
        test_random();
        test_back_to_back();
        test_reset_midflight();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
